// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush/PC-write sequencer for the 5-stage in-order core, with post-reset hold, load-use watchdog and perf counters.
// Latency: stall/flush/PC controls are combinational (0 cycles); state, watchdog and counters update on the next edge.
// Backpressure: dmemBusy freezes the whole pipe, imemBusy stalls fetch only; a redirect during a freeze waits in EX until the exit cycle.
module pipeline_hazard_sequencer #(
    parameter int RESET_HOLD_CYCLES = 4,
    parameter int HAZARD_TIMEOUT    = 3,
    parameter int COUNT_WIDTH       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   isDataHazard,
    input  logic                   branchTaken,
    input  logic                   dmemBusy,
    input  logic                   imemBusy,
    output logic                   ifStall,
    output logic                   idStall,
    output logic                   exStall,
    output logic                   memStall,
    output logic                   idFlush,
    output logic                   exFlush,
    output logic                   memFlush,
    output logic                   pcWriteEnable,
    output logic                   pcLoadTarget,
    output logic                   running,
    output logic                   hazardTimeout,
    output logic [COUNT_WIDTH-1:0] hazardStallCount,
    output logic [COUNT_WIDTH-1:0] flushCount,
    output logic [COUNT_WIDTH-1:0] memWaitCount
);

    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam int WD_W   = $clog2(HAZARD_TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_MAX    = WD_W'(HAZARD_TIMEOUT);

    typedef enum logic [1:0] {
        S_RESET_HOLD = 2'd0,
        S_RUN        = 2'd1,
        S_MEM_WAIT   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   timeout_q, timeout_d;
    logic [COUNT_WIDTH-1:0] haz_cnt_q, haz_cnt_d;
    logic [COUNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic [COUNT_WIDTH-1:0] mw_cnt_q, mw_cnt_d;

    logic active;
    logic freeze;
    logic redirect;
    logic load_use;
    logic fetch_wait;

    // Priority decode: freeze > redirect > load-use > fetch wait; rst or hold forces the frozen pattern
    always_comb begin
        active     = !rst && (state_q != S_RESET_HOLD);
        freeze     = active && dmemBusy;
        redirect   = active && !dmemBusy && branchTaken;
        load_use   = active && !dmemBusy && !branchTaken && isDataHazard;
        fetch_wait = active && !dmemBusy && !branchTaken && !isDataHazard && imemBusy;

        ifStall       = 1'b0;
        idStall       = 1'b0;
        exStall       = 1'b0;
        memStall      = 1'b0;
        idFlush       = 1'b0;
        exFlush       = 1'b0;
        memFlush      = 1'b0;
        pcWriteEnable = 1'b0;
        pcLoadTarget  = 1'b0;
        running       = active;

        if (!active) begin
            {ifStall, idStall, exStall, memStall} = 4'b1111;
            {idFlush, exFlush, memFlush}          = 3'b111;
        end else if (freeze) begin
            {ifStall, idStall, exStall, memStall} = 4'b1111;
            memFlush = 1'b1;
        end else if (redirect) begin
            idFlush       = 1'b1;
            exFlush       = 1'b1;
            pcWriteEnable = 1'b1;
            pcLoadTarget  = 1'b1;
        end else if (load_use) begin
            ifStall = 1'b1;
            idStall = 1'b1;
            exFlush = 1'b1;
        end else if (fetch_wait) begin
            ifStall = 1'b1;
            idFlush = 1'b1;
        end else begin
            pcWriteEnable = 1'b1;
        end
    end

    // Next state, hold counter, watchdog and saturating counters
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            S_RESET_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_RUN, S_MEM_WAIT: state_d = dmemBusy ? S_MEM_WAIT : S_RUN;
            default:           state_d = S_RESET_HOLD;
        endcase

        // only unbroken runs of load-use cycles advance the watchdog
        if (load_use) begin
            wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
        end else begin
            wd_d = '0;
        end
        timeout_d = timeout_q || (wd_d == WD_MAX);

        haz_cnt_d   = (load_use && haz_cnt_q   != '1) ? haz_cnt_q   + COUNT_WIDTH'(1) : haz_cnt_q;
        flush_cnt_d = (redirect && flush_cnt_q != '1) ? flush_cnt_q + COUNT_WIDTH'(1) : flush_cnt_q;
        mw_cnt_d    = (freeze   && mw_cnt_q    != '1) ? mw_cnt_q    + COUNT_WIDTH'(1) : mw_cnt_q;
    end

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RESET_HOLD;
            hold_q      <= '0;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
            haz_cnt_q   <= '0;
            flush_cnt_q <= '0;
            mw_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
            haz_cnt_q   <= haz_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mw_cnt_q    <= mw_cnt_d;
        end
    end

    assign hazardTimeout    = timeout_q;
    assign hazardStallCount = haz_cnt_q;
    assign flushCount       = flush_cnt_q;
    assign memWaitCount     = mw_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Testbench for pipeline_hazard_sequencer: default-parameter instance plus a COUNT_WIDTH=2 instance for saturation.
// Control vectors are queued when inputs are driven and compared on the following falling edge.
// Counter and watchdog values are checked inline one step after the qualifying edge.
module tb_pipeline_hazard_sequencer;

    logic clk;
    logic rst;
    logic isDataHazard, branchTaken, dmemBusy, imemBusy;

    logic ifStall, idStall, exStall, memStall, idFlush, exFlush, memFlush;
    logic pcWriteEnable, pcLoadTarget, running, hazardTimeout;
    logic [31:0] hazardStallCount, flushCount, memWaitCount;

    logic ifStall2, idStall2, exStall2, memStall2, idFlush2, exFlush2, memFlush2;
    logic pcWriteEnable2, pcLoadTarget2, running2, hazardTimeout2;
    logic [1:0] hazardStallCount2, flushCount2, memWaitCount2;

    logic [9:0] ctrl;
    assign ctrl = {ifStall, idStall, exStall, memStall, idFlush, exFlush, memFlush,
                   pcWriteEnable, pcLoadTarget, running};

    // {stalls if,id,ex,mem}, {flushes id,ex,mem}, pcWriteEnable, pcLoadTarget, running
    localparam logic [9:0] C_HOLD   = {4'b1111, 3'b111, 1'b0, 1'b0, 1'b0};
    localparam logic [9:0] C_FREEZE = {4'b1111, 3'b001, 1'b0, 1'b0, 1'b1};
    localparam logic [9:0] C_REDIR  = {4'b0000, 3'b110, 1'b1, 1'b1, 1'b1};
    localparam logic [9:0] C_HAZ    = {4'b1100, 3'b010, 1'b0, 1'b0, 1'b1};
    localparam logic [9:0] C_FETCH  = {4'b1000, 3'b100, 1'b0, 1'b0, 1'b1};
    localparam logic [9:0] C_IDLE   = {4'b0000, 3'b000, 1'b1, 1'b0, 1'b1};

    typedef struct {
        logic [9:0] ctrl;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    pipeline_hazard_sequencer dut (
        .clk(clk), .rst(rst),
        .isDataHazard(isDataHazard), .branchTaken(branchTaken),
        .dmemBusy(dmemBusy), .imemBusy(imemBusy),
        .ifStall(ifStall), .idStall(idStall), .exStall(exStall), .memStall(memStall),
        .idFlush(idFlush), .exFlush(exFlush), .memFlush(memFlush),
        .pcWriteEnable(pcWriteEnable), .pcLoadTarget(pcLoadTarget),
        .running(running), .hazardTimeout(hazardTimeout),
        .hazardStallCount(hazardStallCount), .flushCount(flushCount),
        .memWaitCount(memWaitCount)
    );

    pipeline_hazard_sequencer #(.COUNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .isDataHazard(isDataHazard), .branchTaken(branchTaken),
        .dmemBusy(dmemBusy), .imemBusy(imemBusy),
        .ifStall(ifStall2), .idStall(idStall2), .exStall(exStall2), .memStall(memStall2),
        .idFlush(idFlush2), .exFlush(exFlush2), .memFlush(memFlush2),
        .pcWriteEnable(pcWriteEnable2), .pcLoadTarget(pcLoadTarget2),
        .running(running2), .hazardTimeout(hazardTimeout2),
        .hazardStallCount(hazardStallCount2), .flushCount(flushCount2),
        .memWaitCount(memWaitCount2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: pop one expected control vector per falling edge
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (ctrl !== e.ctrl) begin
                    bad++;
                    $display("FAIL %s: ctrl got=%b want=%b", e.nm, ctrl, e.ctrl);
                end
            end
        end
    endtask

    // One cycle of stimulus; the expected control vector goes to the scoreboard
    task automatic drive(input logic r, input logic dh, input logic bt, input logic dm,
                         input logic im, input logic [9:0] exp, input string nm);
        exp_t e;
        rst = r; isDataHazard = dh; branchTaken = bt; dmemBusy = dm; imemBusy = im;
        e.ctrl = exp;
        e.nm   = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, C_HOLD, "reset_asserted0");
        drive(1, 1, 1, 0, 1, C_HOLD, "reset_asserted1");
        total++;
        if (hazardStallCount !== 32'd0 || flushCount !== 32'd0 || memWaitCount !== 32'd0 || hazardTimeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_counters: got hz=%0d fl=%0d mw=%0d to=%b want 0 0 0 0",
                     hazardStallCount, flushCount, memWaitCount, hazardTimeout);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, C_HOLD, $sformatf("hold_cycle%0d", i));
        drive(0, 0, 0, 0, 0, C_IDLE, "first_run_cycle");
    endtask

    task automatic test_hazard_pulse();
        drive(0, 1, 0, 0, 0, C_HAZ, "load_use_pulse");
        total++;
        if (hazardStallCount !== 32'd1) begin
            bad++;
            $display("FAIL hazard_count_pulse: got=%0d want=1", hazardStallCount);
        end
        total++;
        if (hazardTimeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_after_pulse: got=%b want=0", hazardTimeout);
        end
        drive(0, 0, 0, 0, 0, C_IDLE, "after_pulse");
    endtask

    task automatic test_freeze_branch();
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0, C_FREEZE, $sformatf("freeze%0d", i));
        total++;
        if (flushCount !== 32'd0) begin
            bad++;
            $display("FAIL flush_during_freeze: got=%0d want=0", flushCount);
        end
        drive(0, 0, 1, 0, 0, C_REDIR, "freeze_exit_redirect");
        total++;
        if (memWaitCount !== 32'd3 || flushCount !== 32'd1) begin
            bad++;
            $display("FAIL freeze_counts: got mw=%0d fl=%0d want mw=3 fl=1", memWaitCount, flushCount);
        end
        drive(0, 0, 0, 0, 0, C_IDLE, "after_freeze");
    endtask

    task automatic test_simultaneous();
        drive(0, 1, 1, 0, 1, C_REDIR, "redirect_wins");
        total++;
        if (hazardStallCount !== 32'd1 || flushCount !== 32'd2) begin
            bad++;
            $display("FAIL simultaneous_counts: got hz=%0d fl=%0d want hz=1 fl=2", hazardStallCount, flushCount);
        end
        drive(0, 0, 0, 0, 1, C_FETCH, "fetch_wait");
        drive(0, 1, 0, 0, 1, C_HAZ, "hazard_over_fetch");
        total++;
        if (hazardStallCount !== 32'd2) begin
            bad++;
            $display("FAIL hazard_over_fetch_count: got=%0d want=2", hazardStallCount);
        end
        drive(0, 0, 0, 0, 0, C_IDLE, "after_simultaneous");
    endtask

    task automatic test_timeout();
        drive(0, 1, 0, 0, 0, C_HAZ, "hazard_hold0");
        drive(0, 1, 0, 0, 0, C_HAZ, "hazard_hold1");
        total++;
        if (hazardTimeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: got=%b want=0 after 2 edges", hazardTimeout);
        end
        drive(0, 1, 0, 0, 0, C_HAZ, "hazard_hold2");
        total++;
        if (hazardTimeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_set: got=%b want=1 after 3 edges", hazardTimeout);
        end
        drive(0, 0, 0, 0, 0, C_IDLE, "after_hazard_hold");
        drive(0, 0, 1, 0, 0, C_REDIR, "redirect_after_timeout");
        total++;
        if (hazardTimeout !== 1'b1 || hazardStallCount !== 32'd5) begin
            bad++;
            $display("FAIL timeout_sticky: got to=%b hz=%0d want to=1 hz=5", hazardTimeout, hazardStallCount);
        end
    endtask

    task automatic test_saturation();
        drive(1, 1, 1, 0, 0, C_HOLD, "sat_reset");
        total++;
        if (hazardTimeout !== 1'b0 || flushCount !== 32'd0 || flushCount2 !== 2'd0 || hazardStallCount !== 32'd0) begin
            bad++;
            $display("FAIL rst_clears: got to=%b fl=%0d fl2=%0d hz=%0d want all 0",
                     hazardTimeout, flushCount, flushCount2, hazardStallCount);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, C_HOLD, $sformatf("sat_hold%0d", i));
        total++;
        if (flushCount !== 32'd0) begin
            bad++;
            $display("FAIL no_count_in_hold: got=%0d want=0", flushCount);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 0, C_REDIR, $sformatf("sat_branch%0d", i));
            if (i == 1) begin
                total++;
                if (flushCount2 !== 2'd2) begin
                    bad++;
                    $display("FAIL narrow_count_mid: got=%0d want=2", flushCount2);
                end
            end
        end
        total++;
        if (flushCount2 !== 2'd3 || flushCount !== 32'd5) begin
            bad++;
            $display("FAIL saturation: got fl2=%0d fl=%0d want fl2=3 fl=5", flushCount2, flushCount);
        end
        drive(0, 0, 0, 0, 0, C_IDLE, "after_saturation");
    endtask

    task automatic test_reset_in_memwait();
        drive(0, 0, 0, 1, 0, C_FREEZE, "mw_freeze0");
        drive(0, 0, 0, 1, 0, C_FREEZE, "mw_freeze1");
        total++;
        if (memWaitCount !== 32'd2) begin
            bad++;
            $display("FAIL memwait_before_rst: got=%0d want=2", memWaitCount);
        end
        drive(1, 0, 1, 1, 0, C_HOLD, "rst_in_memwait");
        total++;
        if (memWaitCount !== 32'd0 || flushCount !== 32'd0 || hazardStallCount !== 32'd0) begin
            bad++;
            $display("FAIL rst_in_memwait_counts: got mw=%0d fl=%0d hz=%0d want 0 0 0",
                     memWaitCount, flushCount, hazardStallCount);
        end
        drive(0, 1, 0, 0, 0, C_HOLD, "post_rst_hold0");
        for (int i = 1; i < 4; i++) drive(0, 0, 0, 0, 0, C_HOLD, $sformatf("post_rst_hold%0d", i));
        total++;
        if (hazardStallCount !== 32'd0) begin
            bad++;
            $display("FAIL hold_no_hazard_count: got=%0d want=0", hazardStallCount);
        end
        drive(0, 0, 0, 0, 0, C_IDLE, "post_rst_run");
    endtask

    initial begin
        rst = 1'b1; isDataHazard = 1'b0; branchTaken = 1'b0; dmemBusy = 1'b0; imemBusy = 1'b0;
        fork
            monitor_loop();
        join_none
        @(posedge clk);
        #1;
        test_reset();
        test_hazard_pulse();
        test_freeze_branch();
        test_simultaneous();
        test_timeout();
        test_saturation();
        test_reset_in_memwait();
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
